// File: rtl/uv_residual_sse.sv
// Chroma (U+V) residual rows and sum-of-squared-error accumulator for the UV DC predictor.
// Optional UV_RES_SPLIT_SSE_EN adds separate U and V SSE outputs.
module uv_residual_sse #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned UV_SIZE    = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0]   pred_i,
    input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0]   src_i,
    output logic                                      busy_o,
    output logic                                      res_valid_o,
    output logic [$clog2(UV_SIZE)-1:0]                res_idx_o,
    output logic [BLOCK_SIZE*(BIT_WIDTH+1)-1:0]       res_row_o,
    output logic [2*BIT_WIDTH+6:0]                    sse_o,
`ifdef UV_RES_SPLIT_SSE_EN
    output logic [2*BIT_WIDTH+5:0]                    sse_u_o,
    output logic [2*BIT_WIDTH+5:0]                    sse_v_o,
`endif
    output logic                                      done_o
);

    localparam int unsigned RowW    = BIT_WIDTH * BLOCK_SIZE;
    localparam int unsigned BlkW    = RowW * UV_SIZE;
    localparam int unsigned DiffW   = BIT_WIDTH + 1;
    localparam int unsigned ResW    = BLOCK_SIZE * DiffW;
    localparam int unsigned SqW     = 2 * BIT_WIDTH + 1;
    localparam int unsigned RowSumW = SqW + $clog2(BLOCK_SIZE);
    localparam int unsigned SseW    = 2 * BIT_WIDTH + 7;
    localparam int unsigned IdxW    = $clog2(UV_SIZE);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q;
    logic [BlkW-1:0]      pred_q, src_q;
    logic [IdxW-1:0]      count_q;
    logic                 busy_q, res_valid_q, done_q;
    logic [IdxW-1:0]      res_idx_q;
    logic [ResW-1:0]      res_row_q;

    logic [RowW-1:0]      pred_row, src_row;
    logic [ResW-1:0]      diff_row;
    logic [RowSumW-1:0]   row_sum;
    logic [DiffW-1:0]     diff, mag;
    logic [SqW-1:0]       sq;

    assign pred_row = pred_q[count_q*RowW +: RowW];
    assign src_row  = src_q[count_q*RowW +: RowW];

    // Squares are taken on the magnitude so the multiplier stays unsigned.
    always_comb begin
        diff_row = '0;
        row_sum  = '0;
        diff     = '0;
        mag      = '0;
        sq       = '0;
        for (int c = 0; c < int'(BLOCK_SIZE); c++) begin
            diff = {1'b0, src_row[c*BIT_WIDTH +: BIT_WIDTH]}
                 - {1'b0, pred_row[c*BIT_WIDTH +: BIT_WIDTH]};
            mag  = diff[DiffW-1] ? (~diff + 1'b1) : diff;
            sq   = SqW'(mag) * SqW'(mag);
            diff_row[c*DiffW +: DiffW] = diff;
            row_sum = row_sum + RowSumW'(sq);
        end
    end

`ifdef UV_RES_SPLIT_SSE_EN
    logic [SseW-2:0] sse_u_q, sse_v_q;
    assign sse_u_o = sse_u_q;
    assign sse_v_o = sse_v_q;
    assign sse_o   = {1'b0, sse_u_q} + {1'b0, sse_v_q};
`else
    logic [SseW-1:0] sse_q;
    assign sse_o = sse_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pred_q      <= '0;
            src_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_row_q   <= '0;
            done_q      <= 1'b0;
`ifdef UV_RES_SPLIT_SSE_EN
            sse_u_q     <= '0;
            sse_v_q     <= '0;
`else
            sse_q       <= '0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        pred_q  <= pred_i;
                        src_q   <= src_i;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
`ifdef UV_RES_SPLIT_SSE_EN
                        sse_u_q <= '0;
                        sse_v_q <= '0;
`else
                        sse_q   <= '0;
`endif
                    end
                end
                StCalc: begin
                    res_row_q   <= diff_row;
                    res_idx_q   <= count_q;
                    res_valid_q <= 1'b1;
                    count_q     <= count_q + 1'b1;
`ifdef UV_RES_SPLIT_SSE_EN
                    // Top half of the packed block is U, bottom half is V.
                    if (count_q < IdxW'(UV_SIZE / 2)) begin
                        sse_u_q <= sse_u_q + (SseW-1)'(row_sum);
                    end else begin
                        sse_v_q <= sse_v_q + (SseW-1)'(row_sum);
                    end
`else
                    sse_q <= sse_q + SseW'(row_sum);
`endif
                    if (count_q == IdxW'(UV_SIZE - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_idx_o   = res_idx_q;
    assign res_row_o   = res_row_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_uv_residual_sse.sv
// Directed scoreboard bench for uv_residual_sse; also builds with UV_RES_SPLIT_SSE_EN.
module tb_uv_residual_sse;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1023:0] pred, src;
    logic          busy, res_valid, done;
    logic [3:0]    res_idx;
    logic [71:0]   res_row;
    logic [22:0]   sse;
`ifdef UV_RES_SPLIT_SSE_EN
    logic [21:0]   sse_u, sse_v;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [75:0]   sb[$];
    int            exp_sse, exp_u, exp_v;

    always #5 clk = ~clk;

    uv_residual_sse dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pred_i      (pred),
        .src_i       (src),
        .busy_o      (busy),
        .res_valid_o (res_valid),
        .res_idx_o   (res_idx),
        .res_row_o   (res_row),
        .sse_o       (sse),
`ifdef UV_RES_SPLIT_SSE_EN
        .sse_u_o     (sse_u),
        .sse_v_o     (sse_v),
`endif
        .done_o      (done)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rows are checked as they appear, in order, against what was pushed at start.
    always @(negedge clk) begin
        logic [75:0] e;
        if (res_valid === 1'b1) begin
            check("sb_nonempty", 72'(sb.size() != 0), 72'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_idx", 72'(res_idx), 72'(e[75:72]));
                check("res_row", res_row, e[71:0]);
            end
        end
    end

    task automatic expect_block(input logic [1023:0] p, input logic [1023:0] s,
                                input int nrows);
        int pv, sv, d;
        logic [71:0] row;
        exp_sse = 0;
        exp_u   = 0;
        exp_v   = 0;
        for (int r = 0; r < 16; r++) begin
            row = '0;
            for (int c = 0; c < 8; c++) begin
                pv = int'(p[r*64 + c*8 +: 8]);
                sv = int'(s[r*64 + c*8 +: 8]);
                d  = sv - pv;
                row[c*9 +: 9] = 9'(d);
                exp_sse += d * d;
                if (r < 8) exp_u += d * d;
                else       exp_v += d * d;
            end
            if (r < nrows) sb.push_back({4'(r), row});
        end
    endtask

    // Called at the falling edge of cycle T; returns at the falling edge of T+18,
    // so the next call issues its start at the earliest legal cycle.
    task automatic run_block(input logic [1023:0] p, input logic [1023:0] s,
                             input bit disturb, input logic [1023:0] p2,
                             input logic [1023:0] s2);
        expect_block(p, s, 16);
        pred  = p;
        src   = s;
        start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check($sformatf("busy_T%0d", k), 72'(busy), 72'(k <= 17));
            check($sformatf("valid_T%0d", k), 72'(res_valid), 72'(k >= 2 && k <= 17));
            check($sformatf("done_T%0d", k), 72'(done), 72'(k == 17));
            if (k >= 17) begin
                check("sse", 72'(sse), 72'(exp_sse));
`ifdef UV_RES_SPLIT_SSE_EN
                check("sse_u", 72'(sse_u), 72'(exp_u));
                check("sse_v", 72'(sse_v), 72'(exp_v));
`endif
            end
            start = disturb && (k == 5 || k == 17);
            if (disturb && k == 3) begin
                pred = p2;
                src  = s2;
            end
        end
    endtask

    initial begin
        logic [1023:0] pa, sa, pb, sb_v, pc, sc, ramp, zero;
        zero = '0;
        for (int i = 0; i < 32; i++) begin
            pa[i*32 +: 32]   = $urandom;
            sa[i*32 +: 32]   = $urandom;
            pb[i*32 +: 32]   = $urandom;
            sb_v[i*32 +: 32] = $urandom;
            pc[i*32 +: 32]   = $urandom;
            sc[i*32 +: 32]   = $urandom;
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) ramp[r*64 + c*8 +: 8] = 8'(r);

        // Reset with start held: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        pred  = '0;
        src   = '1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_valid", 72'(res_valid), 72'd0);
        check("rst_idx", 72'(res_idx), 72'd0);
        check("rst_row", res_row, 72'd0);
        check("rst_sse", 72'(sse), 72'd0);
        check("rst_done", 72'(done), 72'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 72'(busy), 72'd0);

        run_block({128{8'h80}}, {128{8'h80}}, 1'b0, zero, zero);
        run_block({128{8'h00}}, {128{8'hFF}}, 1'b0, zero, zero);
        run_block({128{8'hFF}}, {128{8'h00}}, 1'b0, zero, zero);
        run_block(zero, ramp, 1'b0, zero, zero);
        // Ignored starts and input changes mid-block; B is accepted right at T+18.
        run_block(pa, sa, 1'b1, pb, sb_v);
        run_block(pb, sb_v, 1'b0, zero, zero);

        // Reset at T+8: rows 0..6 emitted, then nothing, no done.
        expect_block(pc, sc, 7);
        pred  = pc;
        src   = sc;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k >= 2 && k <= 8) check("rv_pre_rst", 72'(res_valid), 72'd1);
            if (k <= 8) check("done_pre_rst", 72'(done), 72'd0);
            if (k == 8) rst = 1'b1;
            if (k >= 9) begin
                check("rv_post_rst", 72'(res_valid), 72'd0);
                check("busy_post_rst", 72'(busy), 72'd0);
                check("sse_post_rst", 72'(sse), 72'd0);
                check("done_post_rst", 72'(done), 72'd0);
                check("sb_drained", 72'(sb.size()), 72'd0);
                rst = 1'b0;
            end
        end
        run_block(zero, ramp, 1'b0, zero, zero);

        @(negedge clk);
        check("sb_final_empty", 72'(sb.size()), 72'd0);
        check("final_busy", 72'(busy), 72'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uv_residual_sse.md
# uv_residual_sse

Chroma residual and distortion stage directly downstream of the UV DC predictor. It consumes the packed 8x8 U + 8x8 V prediction block (16 rows x 8 samples) together with the co-located source block. It streams signed residual rows, one per cycle, to the UV transform/quantiser, and accumulates the sum of squared errors for the mode-decision cost.

## Interface
Parameters:
- BIT_WIDTH, 8, sample width
- BLOCK_SIZE, 8, samples per row
- UV_SIZE, 16, rows per block (rows 0-7 U, 8-15 V)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only when busy=0
- pred  in  BIT_WIDTH*BLOCK_SIZE*UV_SIZE (1024)  prediction; row r at [r*64 +: 64], sample c at row bits [c*8 +: 8]
- src  in  1024  source block, same packing as pred
- busy  out  1  high from the cycle after accept until the cycle after done
- res_valid  out  1  res_row/res_idx valid
- res_idx  out  4  row index 0..15 of res_row
- res_row  out  BLOCK_SIZE*(BIT_WIDTH+1) (72)  signed residuals src-pred; sample c at [c*9 +: 9], two's complement
- sse  out  2*BIT_WIDTH+7 (23)  combined U+V sum of squared residuals
- done  out  1  one-cycle pulse; sse final

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: on start, register pred and src into internal buffers, clear count and accumulators, then go to CALC. Otherwise stay in IDLE.
- CALC: per cycle, row r=count:
  - compute d_c = src_c - pred_c as 9-bit signed;
  - register the row into res_row with res_idx=r and res_valid=1;
  - add sum(d_c^2) (19-bit row sum) into sse;
  - increment count.
  - When count=15, go to DONE.
- DONE: hold outputs for one cycle, then go to IDLE.
- Input buffers are captured only at accept. Later changes on pred/src do not affect the running block.
- start while busy=1, or in DONE, is ignored; it is not queued.
- Arithmetic is unsigned-extended before subtraction. Squares are 17-bit unsigned. Max sse = 128*255^2 = 8,323,200, which fits 23 bits, so no saturation is needed.
- sse keeps its final value until the next accepted start, which clears it to 0.

## Timing
- Reset: busy=0, res_valid=0, res_idx=0, res_row=0, sse=0, done=0, state IDLE, count=0. Reset wins over start in the same cycle.
- Reset asserted mid-CALC: the block returns to IDLE on the next edge with all outputs at reset values. The partial block is discarded and no done is produced.
- Start accepted in cycle T:
  - res_valid high T+2..T+17, with row r at T+2+r, contiguous and no gaps;
  - done high only at T+17, together with the last row (res_idx=15);
  - sse final at T+17;
  - busy high T+1..T+17, low at T+18;
  - next start is accepted at T+18 at the earliest.
- Throughput: one block per 18 cycles.
- No backpressure: the consumer must accept one row per cycle.

## Configuration
- UV_RES_SPLIT_SSE_EN defined:
  - adds outputs sse_u and sse_v, each 2*BIT_WIDTH+6 (22) bits;
  - sse_u accumulates rows 0-7 and sse_v rows 8-15;
  - sse = sse_u + sse_v;
  - same reset, clear and timing as sse.
- Undefined: only the combined sse port exists, with no extra accumulators.

## Test plan
- pred all 0x80, src all 0x80, start at T -> 16 rows of res_row=0 at T+2..T+17, done at T+17, sse=0.
- src all 0xFF, pred all 0x00 -> every d=+255 (9'h0FF), sse=8,323,200; with UV_RES_SPLIT_SSE_EN, sse_u=sse_v=4,161,600.
- src all 0x00, pred all 0xFF -> every d=-255 (9'h101), sse=8,323,200; sign check.
- src row r = r, pred=0 -> res_idx increments 0..15 in order; sse = 8*sum(r^2, r=0..15) = 9,920.
- start pulsed at T+5 and at T+17, plus pred/src changed at T+3 -> both starts ignored; results match the data captured at T; start at T+18 is accepted.
- rst asserted at T+8 -> at T+9 res_valid=0, busy=0, sse=0; no done; a new start at T+10 produces a clean full block.
